mul_div_unit: RTL

Parametrised, iterative multiply/divide unit that extends the CPU datapath beyond the single-cycle combinational ALU multiply. It supports signed and unsigned multiply and divide, and holds a HI/LO result pair in the MIPS style. It sits beside the ALU: the control unit issues an operation with a start/busy/done handshake, and the core stalls its PC on busy. HI and LO remain readable at all times and are writable through a move-to port.

---
 rtl/mul_div_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative signed/unsigned multiply/divide unit with MIPS-style HI/LO registers.
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator, one bit per clock.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, next_state;

  logic               is_div;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_a;
  logic               neg_b;
  logic               seeded;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;
  logic               dbz_q;

  logic a_neg_in;
  logic b_neg_in;

  assign a_neg_in = op[0] & a[WIDTH-1];
  assign b_neg_in = op[0] & b[WIDTH-1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      IDLE: if (start) next_state = CALC;
      CALC: begin
        busy = 1'b1;
        if (seeded && count == CW'(1)) next_state = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // One iteration: multiply adds the multiplicand into the upper half and
  // shifts right; divide shifts the remainder left and trial-subtracts.
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   step_acc;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, mag_b};
    div_ge    = ~div_diff[WIDTH];
    if (is_div)
      step_acc = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                  acc[WIDTH-2:0], div_ge};
    else
      step_acc = {mul_sum, acc[WIDTH-1:1]};
  end

  // Sign correction applied to the magnitude result as it leaves FIX.
  logic               neg_res;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic               fix_dbz;

  always_comb begin
    neg_res = neg_a ^ neg_b;
    prod    = neg_res ? -acc : acc;
    fix_hi  = prod[2*WIDTH-1:WIDTH];
    fix_lo  = prod[WIDTH-1:0];
    fix_dbz = 1'b0;
    if (is_div) begin
      if (mag_b == '0) begin
        fix_lo  = '1;
        fix_hi  = a_q;
        fix_dbz = 1'b1;
      end else begin
        fix_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_hi = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      is_div <= 1'b0;
      a_q    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      seeded <= 1'b0;
      count  <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            a_q    <= a;
            mag_a  <= a_neg_in ? -a : a;
            mag_b  <= b_neg_in ? -b : b;
            neg_a  <= a_neg_in;
            neg_b  <= b_neg_in;
            count  <= CW'(WIDTH);
            seeded <= 1'b0;
          end else begin
            if (wr_hi) hi_q <= wr_data;
            if (wr_lo) lo_q <= wr_data;
          end
        end
        CALC: begin
          // First CALC clock seeds the accumulator from the latched magnitudes.
          if (!seeded) begin
            seeded <= 1'b1;
            acc    <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
          end else begin
            acc   <= step_acc;
            count <= count - CW'(1);
          end
        end
        FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          dbz_q  <= fix_dbz;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
